// File: rtl/simple_dual_port_dist_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module simple_dual_port_dist_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/narrow_to_wide_fifo.sv
// Width up-converting FIFO: packs WIDTH_RATIO narrow pushes (first in LSBs) into one
// wide RAM entry; flush commits a zero-padded partial word at end of stream.
module narrow_to_wide_fifo #(
    parameter int unsigned INPUT_WIDTH        = 4,
    parameter int unsigned OUTPUT_WIDTH       = 8,
    parameter int unsigned DEPTH              = 6,
    parameter int unsigned ALMOST_EMPTY_COUNT = 1,
    parameter int unsigned ALMOST_FULL_COUNT  = 1,
    parameter int unsigned WIDTH_RATIO        = OUTPUT_WIDTH / INPUT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           flush,
    input  logic                           pop,
    input  logic [INPUT_WIDTH-1:0]         d,
    output logic [OUTPUT_WIDTH-1:0]        q,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH:0]                 count,
    output logic [$clog2(WIDTH_RATIO)-1:0] pack_count,
    output logic                           almost_empty,
    output logic                           almost_full
);

    localparam int unsigned PACK_W    = $clog2(WIDTH_RATIO);
    localparam int unsigned PTR_W     = DEPTH + 1;
    localparam int unsigned ENTRIES   = 2 ** DEPTH;
    localparam int unsigned LAST_LANE = WIDTH_RATIO - 1;
    localparam int unsigned AE_LIM    = 1 + ALMOST_EMPTY_COUNT;
    localparam int unsigned AF_LIM    = ENTRIES - 1 - ALMOST_FULL_COUNT;

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PACK_W-1:0]       pack_count_q, pack_count_d;
    logic [OUTPUT_WIDTH-1:0] pack_q, pack_d;
    logic [OUTPUT_WIDTH-1:0] q_q, q_d;
    logic [OUTPUT_WIDTH-1:0] wdata;
    logic [OUTPUT_WIDTH-1:0] rd_data;
    logic                    ram_full;
    logic                    push_ok;
    logic                    pop_ok;
    logic                    commit;

    // Status derived purely from registered pointers and pack state.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign ram_full     = (wr_ptr_q[DEPTH-1:0] == rd_ptr_q[DEPTH-1:0]) &&
                          (wr_ptr_q[DEPTH] != rd_ptr_q[DEPTH]);
    assign full         = ram_full && (pack_count_q == PACK_W'(LAST_LANE));
    assign almost_empty = (count < PTR_W'(AE_LIM));
    assign almost_full  = (count > PTR_W'(AF_LIM));
    assign pack_count   = pack_count_q;
    assign q            = q_q;

    always_comb begin
        pack_d       = pack_q;
        pack_count_d = pack_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        q_d          = q_q;
        commit       = 1'b0;
        wdata        = pack_q;
        push_ok      = push && !full;
        pop_ok       = pop && !empty;

        if (push_ok) begin
            for (int unsigned k = 0; k < WIDTH_RATIO; k++) begin
                if (pack_count_q == PACK_W'(k)) begin
                    wdata[k*INPUT_WIDTH +: INPUT_WIDTH] = d;
                end
            end
            if (pack_count_q == PACK_W'(LAST_LANE)) begin
                commit = 1'b1;
            end else begin
                pack_count_d = pack_count_q + PACK_W'(1);
            end
        end

        // Flush commits whatever the push left behind; unfilled lanes are already zero.
        if (flush && !commit && !ram_full && (push_ok || pack_count_q != '0)) begin
            commit = 1'b1;
        end

        if (commit) begin
            pack_d       = '0;
            pack_count_d = '0;
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        end else begin
            pack_d = wdata;
        end

        if (pop_ok) begin
            q_d      = rd_data;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pack_count_q <= '0;
            pack_q       <= '0;
            q_q          <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pack_count_q <= pack_count_d;
            pack_q       <= pack_d;
            q_q          <= q_d;
        end
    end

    simple_dual_port_dist_ram #(
        .DATA_WIDTH(OUTPUT_WIDTH),
        .ADDR_WIDTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (commit),
        .waddr(wr_ptr_q[DEPTH-1:0]),
        .wdata(wdata),
        .raddr(rd_ptr_q[DEPTH-1:0]),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_narrow_to_wide_fifo.sv
// Bench for narrow_to_wide_fifo: instance 0 is 4->16 bits with 64 entries,
// instance 1 is 4->8 bits with 4 entries; both checked against a queue-style model.
module tb_narrow_to_wide_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        push_b = 0, flush_b = 0, pop_b = 0;
    logic [3:0]  d_b = '0;
    logic [15:0] q_b;
    logic        full_b, empty_b, ae_b, af_b;
    logic [6:0]  count_b;
    logic [1:0]  pc_b;

    logic        push_c = 0, flush_c = 0, pop_c = 0;
    logic [3:0]  d_c = '0;
    logic [7:0]  q_c;
    logic        full_c, empty_c, ae_c, af_c;
    logic [2:0]  count_c;
    logic [0:0]  pc_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    narrow_to_wide_fifo #(
        .INPUT_WIDTH(4), .OUTPUT_WIDTH(16), .DEPTH(6),
        .ALMOST_EMPTY_COUNT(1), .ALMOST_FULL_COUNT(1)
    ) u_b (
        .clk(clk), .rst(rst), .push(push_b), .flush(flush_b), .pop(pop_b), .d(d_b),
        .q(q_b), .full(full_b), .empty(empty_b), .count(count_b), .pack_count(pc_b),
        .almost_empty(ae_b), .almost_full(af_b)
    );

    narrow_to_wide_fifo #(
        .INPUT_WIDTH(4), .OUTPUT_WIDTH(8), .DEPTH(2),
        .ALMOST_EMPTY_COUNT(1), .ALMOST_FULL_COUNT(1)
    ) u_c (
        .clk(clk), .rst(rst), .push(push_c), .flush(flush_c), .pop(pop_c), .d(d_c),
        .q(q_c), .full(full_c), .empty(empty_c), .count(count_c), .pack_count(pc_c),
        .almost_empty(ae_c), .almost_full(af_c)
    );

    // Reference model: FIFO of wide words plus a partially packed word.
    localparam int CAP   [2] = '{64, 4};
    localparam int RATIO [2] = '{4, 2};

    logic [63:0] m_mem  [2][64];
    logic [63:0] m_pack [2];
    logic [63:0] m_q    [2];
    int          m_pc   [2];
    int          m_cnt  [2];
    int          m_head [2];

    function automatic logic [63:0] act_q(input int w);
        return (w == 0) ? 64'(q_b) : 64'(q_c);
    endfunction

    function automatic int act_count(input int w);
        return (w == 0) ? int'(count_b) : int'(count_c);
    endfunction

    function automatic int act_pc(input int w);
        return (w == 0) ? int'(pc_b) : int'(pc_c);
    endfunction

    // {full, empty, almost_empty, almost_full}
    function automatic logic [3:0] act_flags(input int w);
        return (w == 0) ? {full_b, empty_b, ae_b, af_b} : {full_c, empty_c, ae_c, af_c};
    endfunction

    function automatic logic [3:0] exp_flags(input int w);
        logic f;
        f = (m_cnt[w] == CAP[w]) && (m_pc[w] == RATIO[w] - 1);
        return {f, m_cnt[w] == 0, m_cnt[w] < 2, m_cnt[w] > CAP[w] - 2};
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            m_pack[w] = '0; m_q[w] = '0; m_pc[w] = 0; m_cnt[w] = 0; m_head[w] = 0;
        end
    endtask

    // Reset both instances; optionally with push/pop asserted to show rst dominates.
    task automatic do_reset(input bit with_traffic);
        rst = 1'b1;
        push_b = with_traffic; pop_b = with_traffic; flush_b = with_traffic; d_b = 4'hF;
        push_c = with_traffic; pop_c = with_traffic; flush_c = with_traffic; d_c = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        push_b = 0; pop_b = 0; flush_b = 0; push_c = 0; pop_c = 0; flush_c = 0;
        model_clear();
    endtask

    // One clock on instance w; the model is advanced from pre-edge state.
    task automatic step(input int w, input bit pu, input bit fl, input bit po, input logic [3:0] dd);
        bit          mfull, commit;
        logic [63:0] word;
        int          tail;
        mfull  = (m_cnt[w] == CAP[w]) && (m_pc[w] == RATIO[w] - 1);
        commit = 0;
        word   = '0;
        if (pu && !mfull) begin
            m_pack[w] = m_pack[w] | (64'(dd) << (4 * m_pc[w]));
            m_pc[w]++;
            if (m_pc[w] == RATIO[w]) begin
                commit = 1; word = m_pack[w]; m_pack[w] = '0; m_pc[w] = 0;
            end
        end
        if (fl && !commit && m_pc[w] != 0 && m_cnt[w] < CAP[w]) begin
            commit = 1; word = m_pack[w]; m_pack[w] = '0; m_pc[w] = 0;
        end
        tail = (m_head[w] + m_cnt[w]) % CAP[w];
        if (po && m_cnt[w] > 0) begin
            m_q[w]    = m_mem[w][m_head[w]];
            m_head[w] = (m_head[w] + 1) % CAP[w];
            m_cnt[w]--;
        end
        if (commit) begin
            m_mem[w][tail] = word;
            m_cnt[w]++;
        end
        if (w == 0) begin
            push_b = pu; flush_b = fl; pop_b = po; d_b = dd;
        end else begin
            push_c = pu; flush_c = fl; pop_c = po; d_c = dd;
        end
        @(posedge clk); #1;
        push_b = 0; flush_b = 0; pop_b = 0; push_c = 0; flush_c = 0; pop_c = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (act_flags(w) !== 4'b0110) begin
                n_fail++; $display("FAIL reset_flags inst%0d got=%b exp=0110", w, act_flags(w));
            end
            n_checks++;
            if (act_count(w) !== 0 || act_pc(w) !== 0 || act_q(w) !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d count=%0d pc=%0d q=%h exp 0/0/0",
                         w, act_count(w), act_pc(w), act_q(w));
            end
        end
    endtask

    task automatic test_basic_pack();
        do_reset(1'b0);
        step(1, 1, 0, 0, 4'h3);
        step(1, 1, 0, 0, 4'hA);
        n_checks++;
        if (act_count(1) !== 1) begin
            n_fail++; $display("FAIL basic_count got=%0d exp=1", act_count(1));
        end
        step(1, 0, 0, 1, 4'h0);
        n_checks++;
        if (q_c !== 8'hA3 || empty_c !== 1'b1) begin
            n_fail++; $display("FAIL basic_pop q=%h empty=%b exp q=a3 empty=1", q_c, empty_c);
        end
    endtask

    task automatic test_flush_pad();
        do_reset(1'b0);
        step(0, 1, 0, 0, 4'h1);
        step(0, 1, 0, 0, 4'h2);
        step(0, 0, 1, 0, 4'h0);
        n_checks++;
        if (count_b !== 7'd1 || pc_b !== 2'd0) begin
            n_fail++; $display("FAIL flush_pad_state count=%0d pc=%0d exp 1/0", count_b, pc_b);
        end
        step(0, 0, 0, 1, 4'h0);
        n_checks++;
        if (q_b !== 16'h0021) begin
            n_fail++; $display("FAIL flush_pad_q got=%h exp=0021", q_b);
        end
        // Flush with nothing packed commits nothing.
        step(0, 0, 1, 0, 4'h0);
        n_checks++;
        if (count_b !== 7'd0 || empty_b !== 1'b1) begin
            n_fail++; $display("FAIL flush_empty_noop count=%0d empty=%b exp 0/1", count_b, empty_b);
        end
    endtask

    task automatic test_flush_with_push();
        do_reset(1'b0);
        step(0, 1, 0, 0, 4'h1);
        step(0, 1, 1, 0, 4'h2);
        step(0, 0, 0, 1, 4'h0);
        n_checks++;
        if (q_b !== 16'h0021 || count_b !== 7'd0) begin
            n_fail++; $display("FAIL flush_push q=%h count=%0d exp 0021/0", q_b, count_b);
        end
    endtask

    task automatic test_flush_complete();
        do_reset(1'b0);
        step(0, 1, 0, 0, 4'h1);
        step(0, 1, 0, 0, 4'h2);
        step(0, 1, 0, 0, 4'h3);
        step(0, 1, 1, 0, 4'h4);
        n_checks++;
        if (count_b !== 7'd1 || pc_b !== 2'd0) begin
            n_fail++; $display("FAIL flush_complete_count count=%0d pc=%0d exp 1/0", count_b, pc_b);
        end
        step(0, 0, 0, 1, 4'h0);
        n_checks++;
        if (q_b !== 16'h4321 || empty_b !== 1'b1) begin
            n_fail++; $display("FAIL flush_complete_q q=%h empty=%b exp 4321/1", q_b, empty_b);
        end
    endtask

    task automatic test_full_boundary();
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 4'($urandom));
        n_checks++;
        if (count_c !== 3'd4 || full_c !== 1'b0 || af_c !== 1'b1) begin
            n_fail++; $display("FAIL full_after8 count=%0d full=%b af=%b exp 4/0/1", count_c, full_c, af_c);
        end
        step(1, 1, 0, 0, 4'h7);
        n_checks++;
        if (pc_c !== 1'b1 || full_c !== 1'b1) begin
            n_fail++; $display("FAIL full_after9 pc=%0d full=%b exp 1/1", pc_c, full_c);
        end
        step(1, 1, 0, 0, 4'h9);
        step(1, 0, 1, 0, 4'h0);
        n_checks++;
        if (count_c !== 3'd4 || pc_c !== 1'b1) begin
            n_fail++; $display("FAIL full_ignored count=%0d pc=%0d exp 4/1", count_c, pc_c);
        end
        step(1, 0, 0, 1, 4'h0);
        n_checks++;
        if (full_c !== 1'b0 || q_c !== 8'(m_q[1])) begin
            n_fail++; $display("FAIL full_pop full=%b q=%h exp 0/%h", full_c, q_c, 8'(m_q[1]));
        end
        step(1, 1, 0, 0, 4'h5);
        n_checks++;
        if (count_c !== 3'd4 || pc_c !== 1'b0) begin
            n_fail++; $display("FAIL full_refill count=%0d pc=%0d exp 4/0", count_c, pc_c);
        end
        // The retained partial word survives as 0x57 behind the three older entries.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 4'h0);
        n_checks++;
        if (q_c !== 8'h57) begin
            n_fail++; $display("FAIL full_last_word got=%h exp=57", q_c);
        end
    endtask

    task automatic test_mixed();
        do_reset(1'b0);
        step(1, 1, 0, 0, 4'h5);
        step(1, 1, 0, 0, 4'h6);
        step(1, 0, 0, 1, 4'h0);
        step(1, 0, 0, 1, 4'h0);
        n_checks++;
        if (q_c !== 8'h65 || count_c !== 3'd0) begin
            n_fail++; $display("FAIL pop_empty q=%h count=%0d exp 65/0", q_c, count_c);
        end
        step(1, 1, 0, 0, 4'h1);
        step(1, 1, 0, 0, 4'h2);
        step(1, 1, 0, 0, 4'h3);
        step(1, 1, 0, 1, 4'h4);
        n_checks++;
        if (count_c !== 3'd1 || q_c !== 8'h21) begin
            n_fail++; $display("FAIL commit_and_pop count=%0d q=%h exp 1/21", count_c, q_c);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 4'($urandom));
            step(1, 1, 0, 0, 4'($urandom));
            step(1, 0, 0, 1, 4'h0);
            n_checks++;
            if (q_c !== 8'(m_q[1]) || count_c !== 3'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL wrap_%0d q=%h count=%0d exp %h/%0d", i, q_c, count_c, 8'(m_q[1]), m_cnt[1]);
            end
        end
        do_reset(1'b1);
        n_checks++;
        if (count_c !== 3'd0 || pc_c !== 1'b0 || q_c !== 8'h0 || empty_c !== 1'b1) begin
            n_fail++; $display("FAIL reset_midstream count=%0d pc=%0d q=%h empty=%b", count_c, pc_c, q_c, empty_c);
        end
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int i = 0; i < 600; i++) begin
            int w;
            w = i % 2;
            step(w, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < (w == 0 ? 25 : 40), 4'($urandom));
            n_checks++;
            if (act_count(w) !== m_cnt[w] || act_pc(w) !== m_pc[w] ||
                act_q(w) !== m_q[w] || act_flags(w) !== exp_flags(w)) begin
                n_fail++;
                $display("FAIL random_%0d inst%0d count=%0d pc=%0d q=%h flags=%b exp %0d/%0d/%h/%b",
                         i, w, act_count(w), act_pc(w), act_q(w), act_flags(w),
                         m_cnt[w], m_pc[w], m_q[w], exp_flags(w));
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_pack();
        test_flush_pad();
        test_flush_with_push();
        test_flush_complete();
        test_full_boundary();
        test_mixed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
